// File: rtl/csd_encoder.sv
// Recodes an unsigned multiplier into canonical signed digit form, one digit per clock,
// LSB first, and holds the result with its multiplicand until downstream takes it.
module csd_encoder #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] x_in,
    input  logic [W-1:0] multi,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] x_out,
    output logic [W:0]   pos,
    output logic [W:0]   neg,
    output logic [5:0]   nz_count,
    output logic         busy
);
    localparam int IW = $clog2(W + 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(W - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  shreg;
    logic          carry;
    logic [IW-1:0] idx;

    logic b_cur;
    logic b_nxt;
    logic c_nxt;
    logic d_pos;
    logic d_neg;
    logic last;
    logic accept;

    assign in_ready  = (state == IDLE) && !rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY);
    assign accept    = in_valid && in_ready;

    // Zeros shift in from the top, so b_{i+1} reads as 0 on the final digit.
    always_comb begin
        b_cur = shreg[0];
        b_nxt = shreg[1];
        c_nxt = (b_cur & b_nxt) | (b_cur & carry) | (b_nxt & carry);
        d_pos = (b_cur ^ carry) & ~b_nxt;
        d_neg = (b_cur ^ carry) & b_nxt;
        last  = (idx == LAST_IDX);
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = BUSY;
            BUSY:    if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            x_out    <= '0;
            pos      <= '0;
            neg      <= '0;
            nz_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= multi;
                        x_out    <= x_in;
                        carry    <= 1'b0;
                        idx      <= '0;
                        pos      <= '0;
                        neg      <= '0;
                        nz_count <= '0;
                    end
                end
                BUSY: begin
                    shreg    <= shreg >> 1;
                    carry    <= c_nxt;
                    idx      <= idx + IW'(1);
                    pos[idx] <= d_pos;
                    neg[idx] <= d_neg;
                    // The final carry becomes the top digit and counts as nonzero too.
                    nz_count <= nz_count + 6'(d_pos | d_neg) + 6'(last & c_nxt);
                    if (last) pos[W] <= c_nxt;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/csd_encoder.md
CSD_ENCODER -- requirements
Module: csd_encoder

Interface
REQ-001 Parameter W, default 32, operand and multiplier width in bits; all widths below are given for W=32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers an operand pair.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 x_in  input  W  multiplicand, passed through unchanged.
REQ-007 multi  input  W  unsigned multiplier to recode into canonical signed digit (CSD) form.
REQ-008 out_valid  output  1  recoded result available.
REQ-009 out_ready  input  1  downstream shift-add multiplier accepts the result.
REQ-010 x_out  output  W  captured multiplicand.
REQ-011 pos  output  W+1  bit i set means CSD digit i = +1.
REQ-012 neg  output  W+1  bit i set means CSD digit i = -1.
REQ-013 nz_count  output  6  number of nonzero CSD digits.
REQ-014 busy  output  1  high while in BUSY state.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE and 0 while rst is high; in_valid SHALL be ignored outside IDLE.
REQ-017 IDLE->BUSY on the edge where in_valid && in_ready: capture multi into a shift register, x_in into x_out, clear pos/neg/nz_count, carry c=0, digit index i=0.
REQ-018 BUSY SHALL generate one digit per edge, LSB first (Reitwiesner): b_W = 0; c_next = majority(b_i, b_{i+1}, c); d_i = b_i + c - 2*c_next; set pos[i] if d_i=+1, neg[i] if d_i=-1, and increment nz_count if d_i is nonzero.
REQ-019 On the edge that processes digit W-1, the block SHALL also write digit W = c_next into pos[W] and go to DONE; BUSY SHALL last exactly W edges.
REQ-020 Latency: with acceptance at edge E0, out_valid SHALL be high after edge E0+W (E0+32 at W=32).
REQ-021 DONE SHALL hold out_valid=1 and keep pos, neg, nz_count and x_out stable until an edge with out_ready=1; that edge returns to IDLE and clears out_valid.
REQ-022 The block SHALL accept no new operand in the same cycle that a result is consumed; the earliest re-accept is the next cycle, in IDLE.
REQ-023 Invariants: pos & neg == 0; no two adjacent nonzero digits; sum(pos*2^i) - sum(neg*2^i) == multi; nz_count == popcount(pos) + popcount(neg).
REQ-024 neg[W] SHALL always be 0.
REQ-025 x_out SHALL change only on an accept edge.

Reset
REQ-026 With rst high at an edge, from any state including mid-BUSY or DONE, the block SHALL go to IDLE and clear out_valid, pos, neg, nz_count, x_out, busy, carry and the digit index to 0.
REQ-027 rst SHALL take priority over in_valid and out_ready on the same edge.

Verification
REQ-028 multi=3, x_in=5, out_ready=1 -> out_valid exactly 32 edges after accept; pos=0x4, neg=0x1, nz_count=2, x_out=5.
REQ-029 multi=0xFFFFFFFF -> pos=0x1_0000_0000 (bit 32), neg=0x1, nz_count=2.
REQ-030 multi=0x55555555 -> pos=0x55555555, neg=0, nz_count=16; multi=0 -> pos=0, neg=0, nz_count=0.
REQ-031 out_ready held low for 5 cycles after out_valid, in_valid pulsed during that time -> outputs stable, in_ready=0, no new capture; consume, then in_ready=1 on the next cycle.
REQ-032 rst pulsed at the 10th BUSY edge -> next cycle IDLE, in_ready=1, out_valid=0, all outputs 0; a following operand multi=7 -> pos=0x8, neg=0x1, nz_count=2.
REQ-033 A random-multi regression (at least 1000 vectors) SHALL check every REQ-023 invariant on every result.
